// File: rtl/moving_average_scheduler_types.sv
// Shared definitions for the moving-average scheduler.
// Holds the default sample width and window length, the window, accumulator
// and per-channel state types, the sequencer state encoding and helpers that
// flatten the typed values into plain vectors for inspection.
package moving_average_scheduler_types;

    localparam int DEF_W    = 8;
    localparam int DEF_TAPS = 16;
    localparam int DEF_LT   = $clog2(DEF_TAPS);

    typedef logic signed [DEF_W-1:0]        sample_t;
    typedef sample_t                        window_t [DEF_TAPS];
    typedef logic signed [DEF_W+DEF_LT-1:0] acc_t;

    typedef struct packed {
        logic [DEF_LT-1:0] wptr;
        logic [DEF_LT:0]   fill;
        acc_t              sum;
    } chan_state_t;

    // Sequencer encoding: plain constants so the state register stays a
    // bare vector; the enum carries the same values for readable dumps.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_UPDATE = S_UPDATE,
        ST_OUT    = S_OUT
    } state_e;

    function automatic logic [$bits(chan_state_t)-1:0] chan_state_to_lv(input chan_state_t s);
        return s;
    endfunction

    function automatic logic [1:0] state_to_lv(input state_e s);
        return s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// i_req  : request vector, one bit per channel
// i_last : index of the most recently granted channel
// o_grant: one-hot grant (all zero when nothing requests); the search starts
//          at the channel after i_last and wraps around.
module rr_arbiter
    import moving_average_scheduler_types::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         i_req,
    input  logic [$clog2(NCH)-1:0] i_last,
    output logic [NCH-1:0]         o_grant
);

    localparam int CW = $clog2(NCH);

    logic [CW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // NCH is a power of two, so CW-bit addition wraps the search for free;
        // k == NCH lands back on i_last itself as the lowest priority.
        for (int k = 1; k <= NCH; k++) begin
            w_idx = i_last + CW'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/moving_average_scheduler.sv
// Shares one moving-average update datapath among NCH sample streams.
// in_valid/in_ready : per-channel sample handshake; in_ready is a one-hot grant
//                     and a sample moves on a clock edge where valid & ready.
// in_data           : channel i occupies bits [i*W +: W], signed
// clr               : per-channel clear pulse, latched until served in IDLE
// out_valid/out_ready: result handshake; outputs hold steady while valid & !ready
// out_ch/out_sum/out_avg/out_full: channel, window sum, floored average and
//                     window-full flag of the result
// busy              : sequencer active or a clear still pending
module moving_average_scheduler
    import moving_average_scheduler_types::*;
#(
    parameter int NCH  = 4,
    parameter int TAPS = DEF_TAPS,
    parameter int W    = DEF_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NCH-1:0]              in_valid,
    input  logic [NCH*W-1:0]            in_data,
    output logic [NCH-1:0]              in_ready,
    input  logic [NCH-1:0]              clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NCH)-1:0]      out_ch,
    output logic [W+$clog2(TAPS)-1:0]   out_sum,
    output logic [W-1:0]                out_avg,
    output logic                        out_full,
    output logic                        busy
);

    localparam int CW = $clog2(NCH);
    localparam int LT = $clog2(TAPS);
    localparam int SW = W + LT;
    localparam logic [LT:0] FILL_MAX = (LT+1)'(TAPS);

    logic [1:0]             r_state;
    logic [NCH-1:0]         r_pend_clr;
    logic [CW-1:0]          r_last;
    logic [CW-1:0]          r_ch;
    logic signed [W-1:0]    r_x;
    logic [LT-1:0]          r_wptr [NCH];
    logic [LT:0]            r_fill [NCH];
    logic signed [SW-1:0]   r_sum  [NCH];
    logic signed [W-1:0]    r_win  [NCH][TAPS];
    logic                   r_out_valid;
    logic [CW-1:0]          r_out_ch;
    logic [SW-1:0]          r_out_sum;
    logic                   r_out_full;

    logic                   w_idle;
    logic                   w_clr_any;
    logic [NCH-1:0]         w_arb_grant;
    logic [NCH-1:0]         w_grant;
    logic [CW-1:0]          w_grant_idx;
    logic signed [W-1:0]    w_x;
    logic [NCH-1:0]         w_clr_sel;
    logic [NCH-1:0]         w_clr_done;
    logic [CW-1:0]          w_clr_idx;
    logic signed [W-1:0]    w_old;
    logic signed [SW:0]     w_new_sum;
    logic [LT:0]            w_new_fill;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .i_req   (in_valid),
        .i_last  (r_last),
        .o_grant (w_arb_grant)
    );

    assign w_idle    = (r_state == S_IDLE);
    assign w_clr_any = |r_pend_clr;
    // Pending clears take the IDLE cycle ahead of any grant.
    assign w_grant   = (w_idle && !w_clr_any && !rst) ? w_arb_grant : '0;
    assign in_ready  = w_grant;

    // Lowest set bit of the pending-clear vector.
    assign w_clr_sel  = r_pend_clr & (~r_pend_clr + 1'b1);
    assign w_clr_done = w_idle ? w_clr_sel : '0;

    always_comb begin
        w_grant_idx = '0;
        w_x         = '0;
        w_clr_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = CW'(i);
                w_x         = in_data[i*W +: W];
            end
            if (w_clr_sel[i]) begin
                w_clr_idx = CW'(i);
            end
        end
    end

    // Until the window is full the evicted sample is an implicit zero.
    assign w_old      = (r_fill[r_ch] == FILL_MAX) ? r_win[r_ch][r_wptr[r_ch]] : '0;
    assign w_new_sum  = r_sum[r_ch] + r_x - w_old;
    assign w_new_fill = (r_fill[r_ch] == FILL_MAX) ? FILL_MAX : r_fill[r_ch] + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend_clr  <= '0;
            r_last      <= CW'(NCH - 1);
            r_ch        <= '0;
            r_x         <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_sum   <= '0;
            r_out_full  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_wptr[i] <= '0;
                r_fill[i] <= '0;
                r_sum[i]  <= '0;
            end
        end else begin
            // New pulses merge with what is already pending.
            r_pend_clr <= (r_pend_clr & ~w_clr_done) | clr;
            case (r_state)
                S_IDLE: begin
                    if (w_clr_any) begin
                        r_wptr[w_clr_idx] <= '0;
                        r_fill[w_clr_idx] <= '0;
                        r_sum[w_clr_idx]  <= '0;
                    end else if (|w_grant) begin
                        r_ch    <= w_grant_idx;
                        r_x     <= w_x;
                        r_last  <= w_grant_idx;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_sum[r_ch]  <= w_new_sum[SW-1:0];
                    r_wptr[r_ch] <= r_wptr[r_ch] + 1'b1;
                    r_fill[r_ch] <= w_new_fill;
                    r_out_valid  <= 1'b1;
                    r_out_ch     <= r_ch;
                    r_out_sum    <= w_new_sum[SW-1:0];
                    r_out_full   <= (w_new_fill == FILL_MAX);
                    r_state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Window memory carries no reset: fill = 0 marks its contents as unused.
    always_ff @(posedge clk) begin
        if (r_state == S_UPDATE) begin
            r_win[r_ch][r_wptr[r_ch]] <= r_x;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_sum   = r_out_sum;
    // Top W bits of the sum are the arithmetic shift by log2(TAPS).
    assign out_avg   = r_out_sum[SW-1:LT];
    assign out_full  = r_out_full;
    assign busy      = !w_idle || w_clr_any;

endmodule

// File: tb/tb_moving_average_scheduler.sv
module tb_moving_average_scheduler;
  localparam int NCH  = 4;
  localparam int TAPS = 16;
  localparam int W    = 8;
  localparam int LT   = 4;
  localparam int SW   = W + LT;
  localparam int CW   = 2;
  localparam int EW   = CW + 1 + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   clr;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_ch;
  logic [SW-1:0]    out_sum;
  logic [W-1:0]     out_avg;
  logic             out_full;
  logic             busy;

  always #5 clk = ~clk;

  moving_average_scheduler #(.NCH(NCH), .TAPS(TAPS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_full  (out_full),
    .busy      (busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Each channel keeps its last TAPS samples; sum is their plain total.
  int win_q [NCH][$];
  logic [EW-1:0] exp_q[$];
  int  m_last;
  int  cyc = 0;
  int  last_grant_cyc;
  bit  have_grant;
  bit  spacing_en = 0;
  int  n_results = 0;
  int  last_sum, last_avg;
  logic last_full;
  logic stall_prev;
  logic [CW-1:0] p_ch;
  logic [SW-1:0] p_sum;
  logic [W-1:0]  p_avg;
  logic          p_full;
  int  g, gi, s, es;
  logic signed [W-1:0] x;
  logic [EW-1:0] e;

  function automatic int rr_predict(input int last, input logic [NCH-1:0] req);
    for (int k = 1; k <= NCH; k++) begin
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_last = NCH - 1;
      exp_q.delete();
      for (int i = 0; i < NCH; i++) win_q[i].delete();
      stall_prev = 1'b0;
      have_grant = 1'b0;
    end else begin
      check("in_ready_onehot0", 32'($countones(in_ready) <= 1), 1);
      if (|(in_valid & in_ready)) begin
        g  = rr_predict(m_last, in_valid);
        gi = 0;
        for (int i = 0; i < NCH; i++) if (in_ready[i]) gi = i;
        check("grant_order", gi, g);
        if (spacing_en && have_grant) check("grant_spacing", cyc - last_grant_cyc, 3);
        have_grant     = 1'b1;
        last_grant_cyc = cyc;
        m_last         = gi;
        x = in_data[gi*W +: W];
        win_q[gi].push_back(int'(x));
        if (win_q[gi].size() > TAPS) void'(win_q[gi].pop_front());
        s = 0;
        for (int j = 0; j < win_q[gi].size(); j++) s += win_q[gi][j];
        exp_q.push_back({CW'(gi), (win_q[gi].size() == TAPS), SW'(s)});
      end
      for (int i = 0; i < NCH; i++) if (clr[i]) win_q[i].delete();

      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_ch", out_ch, p_ch);
        check("stall_sum", out_sum, p_sum);
        check("stall_avg", out_avg, p_avg);
        check("stall_full", out_full, p_full);
      end
      if (out_valid) begin
        check("no_grant_in_out", in_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e  = exp_q.pop_front();
            es = int'($signed(e[SW-1:0]));
            check("out_ch", out_ch, e[EW-1 -: CW]);
            check("out_full", out_full, e[SW]);
            check("out_sum", int'($signed(out_sum)), es);
            check("out_avg", int'($signed(out_avg)), es >>> LT);
          end
          last_sum  = int'($signed(out_sum));
          last_avg  = int'($signed(out_avg));
          last_full = out_full;
          n_results++;
        end
      end
      stall_prev = out_valid && !out_ready;
      p_ch = out_ch; p_sum = out_sum; p_avg = out_avg; p_full = out_full;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int n, input int budget);
    int t = 0;
    while (n_results < n && t < budget) begin
      tick();
      t++;
    end
    if (n_results < n) check("timeout_results", n_results, n);
  endtask

  task automatic wait_out_valid(input int budget);
    int t = 0;
    while (!out_valid && t < budget) begin
      tick();
      t++;
    end
    if (!out_valid) check("timeout_out_valid", 0, 1);
  endtask

  task automatic set_ch(input int ch, input logic v, input logic signed [W-1:0] d);
    in_valid[ch]        = v;
    in_data[ch*W +: W]  = d;
  endtask

  // ---------------- test sequence ----------------
  logic [NCH-1:0] xfer;
  int n0, t;

  initial begin
    rst = 1'b1; in_valid = '1; in_data = '0; clr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_avg", out_avg, 0);
    check("rst_out_full", out_full, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    in_valid = '0;
    rst = 1'b0;
    tick();

    // warm-up: ch0, sixteen samples of 16, grants 3 cycles apart
    out_ready  = 1'b1;
    spacing_en = 1'b1;
    n0 = n_results;
    set_ch(0, 1'b1, 8'sd16);
    wait_results(n0 + 15, 200);
    check("warm15_sum", last_sum, 240);
    check("warm15_full", last_full, 0);
    wait_results(n0 + 16, 50);
    set_ch(0, 1'b0, 8'sd0);
    spacing_en = 1'b0;
    check("warm16_sum", last_sum, 256);
    check("warm16_avg", last_avg, 16);
    check("warm16_full", last_full, 1);

    // wrap: one sample of 17, then fifteen more
    set_ch(0, 1'b1, 8'sd17);
    wait_results(n0 + 17, 50);
    set_ch(0, 1'b0, 8'sd0);
    check("wrap1_sum", last_sum, 257);
    check("wrap1_avg", last_avg, 16);
    set_ch(0, 1'b1, 8'sd17);
    wait_results(n0 + 32, 200);
    set_ch(0, 1'b0, 8'sd0);
    check("wrap16_sum", last_sum, 272);
    check("wrap16_avg", last_avg, 17);

    // round-robin across all channels
    n0 = n_results;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, W'(i + 1));
    wait_results(n0 + 48, 400);
    in_valid = '0;

    // backpressure: result held 10 cycles while ch0 waits
    out_ready = 1'b0;
    n0 = n_results;
    set_ch(1, 1'b1, 8'sd50);
    wait_out_valid(20);
    set_ch(1, 1'b0, 8'sd0);
    set_ch(0, 1'b1, 8'sd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_results(n0 + 2, 50);
    set_ch(0, 1'b0, 8'sd0);

    // clear of ch2 while its result waits in OUT
    out_ready = 1'b0;
    n0 = n_results;
    set_ch(2, 1'b1, 8'sd9);
    wait_out_valid(20);
    set_ch(2, 1'b0, 8'sd0);
    clr = 4'b0100;
    tick();
    clr = '0;
    tick();
    check("clr_busy_out", busy, 1);
    check("clr_held_valid", out_valid, 1);
    set_ch(2, 1'b1, -8'sd8);
    out_ready = 1'b1;
    tick();
    check("clr_no_grant", in_ready, 0);
    check("clr_busy_idle", busy, 1);
    tick();
    check("clr_then_grant", in_ready, 4'b0100);
    wait_results(n0 + 2, 50);
    set_ch(2, 1'b0, 8'sd0);
    check("clr_sum", last_sum, -8);
    check("clr_avg", last_avg, -1);
    check("clr_full", last_full, 0);

    // extremes: ch3 sixteen samples of -128
    n0 = n_results;
    set_ch(3, 1'b1, -8'sd128);
    wait_results(n0 + 16, 200);
    set_ch(3, 1'b0, 8'sd0);
    check("ext_sum", last_sum, -2048);
    check("ext_avg", last_avg, -128);
    check("ext_full", last_full, 1);

    // reset asserted while a sample is in UPDATE
    set_ch(0, 1'b1, 8'sd5);
    t = 0;
    while (!in_ready[0] && t < 20) begin tick(); t++; end
    check("rst_mid_grant", in_ready[0], 1);
    tick();
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_ch", out_ch, 0);
    check("rstmid_out_sum", out_sum, 0);
    check("rstmid_out_avg", out_avg, 0);
    check("rstmid_out_full", out_full, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", in_ready, 0);
    repeat (3) tick();
    check("rstmid_hold_busy", busy, 0);
    set_ch(0, 1'b0, 8'sd0);
    rst = 1'b0;
    tick();
    n0 = n_results;
    set_ch(0, 1'b1, 8'sd20);
    wait_results(n0 + 1, 20);
    set_ch(0, 1'b0, 8'sd0);
    check("post_rst_sum", last_sum, 20);
    check("post_rst_full", last_full, 0);

    // randomized traffic, backpressure and clears
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      xfer = in_valid & in_ready;
      tick();
      for (int i = 0; i < NCH; i++) begin
        if (xfer[i] || !in_valid[i]) begin
          in_valid[i]       = ($urandom_range(0, 2) != 0);
          in_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr = '0;
      if ($urandom_range(0, 29) == 0) clr[$urandom_range(0, NCH-1)] = 1'b1;
    end
    tick();
    in_valid = '0; clr = '0; out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 100) begin tick(); t++; end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
